// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The packet layout here is the word pushed into the decode instruction queue.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned InstrBytes = 4;

    // The PC sits in the upper half so decode can slice it without unpacking.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(InstrBytes - 1);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// In-order fetch front end: issues word reads, tags responses with their PC and
// pushes {pc, instr} into the decode queue under credit-based flow control.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     Width              = XLEN,
    parameter logic [Width-1:0] ResetPc           = '0,
    parameter int unsigned     MaxOutstandingLog2 = 2,
    parameter int unsigned     CreditsLog2        = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             redirect_valid_i,
    input  logic [Width-1:0] redirect_pc_i,
    output logic             mem_valid_o,
    output logic [Width-1:0] mem_addr_o,
    input  logic             mem_ready_i,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i,
    output logic             out_valid_o,
    output fetch_pkt_t       out_data_o,
    input  logic             out_ready_i,
    input  logic             credit_return_i
);

    localparam int unsigned OutW = MaxOutstandingLog2 + 1;
    localparam int unsigned CrW  = CreditsLog2 + 1;

    localparam logic [OutW-1:0]  OutLimit    = OutW'(2 ** MaxOutstandingLog2);
    localparam logic [CrW-1:0]   CreditsFull = CrW'(2 ** CreditsLog2);
    localparam logic [Width-1:0] PcStep      = Width'(InstrBytes);

    logic [Width-1:0] pc_q, pc_d;
    logic [Width-1:0] rsp_pc_q, rsp_pc_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d;
    logic [OutW-1:0]  discard_q, discard_d;
    logic [CrW-1:0]   credits_q, credits_d;
    logic [CrW:0]     credits_wide;
    fetch_state_e     state_q, state_d;

    logic             issue;
    logic             drop;
    logic             deliver;
    logic [Width-1:0] redirect_target;

    assign redirect_target = word_align(redirect_pc_i);

    // Redirect cycles never issue: the request would carry a PC about to be replaced.
    assign mem_valid_o = !rst_i && !redirect_valid_i
                      && (outstanding_q < OutLimit) && (credits_q != '0);
    assign mem_addr_o  = pc_q;

    assign issue   = mem_valid_o && mem_ready_i;
    assign drop    = mem_rvalid_i && ((state_q == DRAIN) || redirect_valid_i);
    assign deliver = mem_rvalid_i && !drop;

    assign out_valid_o = !rst_i && deliver;
    assign out_data_o  = '{pc: rsp_pc_q, instr: mem_rdata_i};

    // A dropped response never reaches the queue, so its slot is handed back at once.
    assign credits_wide = {1'b0, credits_q}
                        + {{CrW{1'b0}}, credit_return_i}
                        + {{CrW{1'b0}}, drop}
                        - {{CrW{1'b0}}, issue};

    // NOTE: combinational next-state logic uses blocking assignments and gives
    // every target a default first, so no latch can be inferred.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        credits_d     = credits_wide[CrW-1:0];
        outstanding_d = outstanding_q + OutW'(issue) - OutW'(mem_rvalid_i);

        if (redirect_valid_i) begin
            pc_d      = redirect_target;
            rsp_pc_d  = redirect_target;
            // Everything still in flight belongs to the abandoned path.
            discard_d = outstanding_q - OutW'(mem_rvalid_i);
        end else begin
            if (issue) begin
                pc_d = pc_q + PcStep;
            end
            if (deliver) begin
                rsp_pc_d = rsp_pc_q + PcStep;
            end
            if (mem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - OutW'(1);
            end
        end

        state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    // NOTE: sequential state uses non-blocking assignments only; every register
    // here is a small counter or PC, so all of them take a reset value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= ResetPc;
            rsp_pc_q      <= ResetPc;
            outstanding_q <= '0;
            discard_q     <= '0;
            credits_q     <= CreditsFull;
            state_q       <= RUN;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            credits_q     <= credits_d;
            state_q       <= state_d;
        end
    end

    // The credit scheme guarantees the queue is never full when a packet arrives.
    a_out_ready : assert property (@(posedge clk_i) disable iff (rst_i)
        out_valid_o |-> out_ready_i);

    a_rsp_expected : assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> (outstanding_q != '0));

    // An underflow wraps the wide sum to a large value, so one bound covers both.
    a_credits_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        credits_wide <= {1'b0, CreditsFull});

    a_outstanding_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_q <= OutLimit);

endmodule
